// File: rtl/regfile_pkg.sv
// Shared register-file constants and types.
package regfile_pkg;

  localparam int unsigned REG_AW = 5;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned NREG   = 32;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  localparam reg_addr_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rr_arbiter.sv
// Stateless round-robin arbiter: first requester at or above i_ptr (wrapping) wins.
module rr_arbiter #(
  parameter int unsigned N     = 3,
  parameter int unsigned PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     i_req,
  input  logic [PTR_W-1:0] i_ptr,
  output logic [N-1:0]     o_gnt,
  output logic [PTR_W-1:0] o_idx,
  output logic             o_any
);

  logic [PTR_W-1:0] w_j;

  always_comb begin
    o_gnt = '0;
    o_idx = '0;
    o_any = 1'b0;
    w_j   = '0;
    for (int unsigned off = 0; off < N; off++) begin
      w_j = PTR_W'((32'(i_ptr) + off) % N);
      if (!o_any && i_req[w_j]) begin
        o_gnt[w_j] = 1'b1;
        o_idx      = w_j;
        o_any      = 1'b1;
      end
    end
  end

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Write-back arbiter for the register-file write port plus pending-write scoreboard.
// Scoreboard is built only when SCOREBOARD_EN is defined.
module regfile_wb_arbiter
  import regfile_pkg::*;
#(
  parameter int unsigned NREQ  = 3,
  parameter int unsigned CNT_W = 2
) (
  input  logic                   CLK,
  input  logic                   reset,
  input  logic [NREQ-1:0]        req_valid,
  input  logic [NREQ*REG_AW-1:0] req_wa,
  input  logic [NREQ*DATA_W-1:0] req_wd,
  output logic [NREQ-1:0]        req_ready,
  output logic                   rf_we,
  output reg_addr_t              rf_wa,
  output reg_data_t              rf_wd,
  input  logic                   rsv_en,
  input  reg_addr_t              rsv_wa,
  output logic                   rsv_full,
  input  reg_addr_t              chk_ra1,
  input  reg_addr_t              chk_ra2,
  output logic                   chk_busy1,
  output logic                   chk_busy2
);

  localparam int unsigned PTR_W = $clog2(NREQ);

  logic [PTR_W-1:0] r_ptr;
  logic [NREQ-1:0]  w_gnt;
  logic [PTR_W-1:0] w_idx;
  logic             w_any;
  reg_addr_t        w_wa;
  reg_data_t        w_wd;
  logic             r_we;
  reg_addr_t        r_wa;
  reg_data_t        r_wd;

  rr_arbiter #(
    .N     (NREQ),
    .PTR_W (PTR_W)
  ) u_rr_arbiter (
    .i_req (req_valid),
    .i_ptr (r_ptr),
    .o_gnt (w_gnt),
    .o_idx (w_idx),
    .o_any (w_any)
  );

  assign req_ready = w_gnt;

  // Grant is one-hot, so an OR-select picks the winner's address/data.
  always_comb begin
    w_wa = '0;
    w_wd = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (w_gnt[i]) begin
        w_wa = w_wa | req_wa[i*REG_AW +: REG_AW];
        w_wd = w_wd | req_wd[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_ptr <= '0;
      r_we  <= 1'b0;
      r_wa  <= '0;
      r_wd  <= '0;
    end else if (w_any) begin
      r_ptr <= (w_idx == PTR_W'(NREQ - 1)) ? '0 : w_idx + 1'b1;
      r_we  <= (w_wa != ZERO_REG);
      r_wa  <= w_wa;
      r_wd  <= w_wd;
    end else begin
      r_we  <= 1'b0;
    end
  end

  assign rf_we = r_we;
  assign rf_wa = r_wa;
  assign rf_wd = r_wd;

`ifdef SCOREBOARD_EN
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  logic [CNT_W-1:0] r_cnt [NREG];
  logic             w_inc;
  logic             w_dec;

  assign w_inc = rsv_en && (rsv_wa != ZERO_REG) && (r_cnt[rsv_wa] != CNT_MAX);
  assign w_dec = w_any && (w_wa != ZERO_REG) && (r_cnt[w_wa] != '0);

  // Register 0 is never selected by w_inc/w_dec, so its counter stays at reset value.
  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREG; i++) r_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NREG; i++) begin
        if (w_inc && (rsv_wa == REG_AW'(i)) && !(w_dec && (w_wa == REG_AW'(i)))) begin
          r_cnt[i] <= r_cnt[i] + 1'b1;
        end else if (w_dec && (w_wa == REG_AW'(i)) &&
                     !(w_inc && (rsv_wa == REG_AW'(i)))) begin
          r_cnt[i] <= r_cnt[i] - 1'b1;
        end
      end
    end
  end

  assign rsv_full  = (rsv_wa != ZERO_REG) && (r_cnt[rsv_wa] == CNT_MAX);
  assign chk_busy1 = (r_cnt[chk_ra1] != '0);
  assign chk_busy2 = (r_cnt[chk_ra2] != '0);
`else
  logic [CNT_W-1:0] w_unused_cnt;
  logic             w_unused_in;

  assign w_unused_cnt = '0;
  assign w_unused_in  = ^{rsv_en, rsv_wa, chk_ra1, chk_ra2, w_unused_cnt};
  assign rsv_full     = 1'b0;
  assign chk_busy1    = 1'b0;
  assign chk_busy2    = 1'b0;
`endif

endmodule

// File: doc/regfile_wb_arbiter.md
# regfile_wb_arbiter

Write-back arbiter and pending-write scoreboard for the 32×32 register file. Shares the file's single write port between NREQ write-back sources (ALU, load unit, multiply/divide) with round-robin grant and valid/ready handshake. Tracks outstanding writes per register so the issue stage can detect RAW/WAW hazards. Sits between the execute/memory back-ends and the register file's write port, and drives its write enable, address and data.

## Interface
Parameters:
- NREQ, 3, number of write-back requesters (2..8)
- CNT_W, 2, width of each per-register pending-write counter

Ports:
- CLK  in  1  clock; all state updates on posedge
- reset  in  1  asynchronous, active-high reset
- req_valid  in  NREQ  requester i has a write pending
- req_wa  in  NREQ×5  destination register of requester i (bits 5i+4:5i)
- req_wd  in  NREQ×32  write data of requester i
- req_ready  out  NREQ  one-hot grant; combinational; accept = valid & ready
- rf_we  out  1  register-file write enable (registered)
- rf_wa  out  5  register-file write address (registered)
- rf_wd  out  32  register-file write data (registered)
- rsv_en  in  1  issue stage reserves a destination register
- rsv_wa  in  5  register being reserved
- rsv_full  out  1  counter[rsv_wa] is at maximum; combinational
- chk_ra1, chk_ra2  in  5  source registers to check
- chk_busy1, chk_busy2  out  1  counter[chk_raN] != 0; combinational

## Operation
- Arbitration: round-robin pointer ptr (0..NREQ-1).
  - Search starts at ptr and wraps upward; the first valid requester gets req_ready.
  - At most one ready bit is set. All ready bits are 0 when no requester is valid.
  - After an accept by requester g, ptr <= (g+1) mod NREQ. With no accept, ptr holds.
- Write port: on an accept, rf_we <= (req_wa[g] != 0), rf_wa <= req_wa[g], rf_wd <= req_wd[g].
  - With no accept, rf_we <= 0; rf_wa and rf_wd hold.
  - A write to register 0 is accepted and acknowledged but never written.
- Requesters may drop valid without an accept. wa/wd must be stable while valid & !ready.
- Scoreboard: 32 counters, each CNT_W bits wide.
  - Increment counter[rsv_wa] on rsv_en when rsv_wa != 0 and the counter is not at maximum.
  - Decrement counter[req_wa[g]] on an accept when req_wa[g] != 0 and the counter is not 0. Decrement is floored at 0.
  - Increment and decrement of the same register in the same cycle: counter unchanged.
  - rsv_en while rsv_full: the reservation is ignored. The issue stage must stall on rsv_full.
  - Register 0: counter constantly 0; chk_busy for it is always 0; rsv_full for it is always 0.

## Timing
- Reset values:
  - ptr = 0
  - all counters = 0
  - rf_we = 0, rf_wa = 0, rf_wd = 0
  - req_ready follows req_valid with ptr = 0
  - rsv_full = 0, chk_busy1 = 0, chk_busy2 = 0
- Reset asserted mid-operation discards the in-flight write. rf_we drops immediately and no write reaches the file.
- Accept at posedge k drives rf_* during cycle k. The register file captures the write at the negedge inside cycle k.
- The counter decrement also takes effect at posedge k, so chk_busy falls in cycle k. A decode stage sampling reads at posedge k+1 sees the new value.
- Grant latency: 0 cycles (combinational ready). Sustained throughput: one write per cycle.
- A requester held valid under full contention is granted within NREQ cycles.

## Configuration
- SCOREBOARD_EN defined: counters, rsv_full and chk_busy1/2 are implemented as above.
- SCOREBOARD_EN undefined:
  - no counter storage
  - rsv_full, chk_busy1, chk_busy2 tied to 0
  - rsv_* and chk_* inputs ignored
  - arbitration and the write port are unchanged

## Structure
- Shared package regfile_pkg:
  - REG_AW = 5
  - DATA_W = 32
  - NREG = 32
  - ZERO_REG = 5'd0
  - typedef reg_addr_t (logic [4:0])
  - typedef reg_data_t (logic [31:0])
- Sub-module rr_arbiter (parameter N): inputs req[N] and ptr; outputs the one-hot grant and the grant index. It contains no state; ptr is held in the parent.

## Test plan
- Reset: assert reset mid-write with rf_we = 1 → rf_we, rf_wa, rf_wd go to 0 immediately; after release, counters are 0 and ptr = 0.
- Single write: requester 1 valid, wa = 5, wd = 0xDEADBEEF → req_ready = 3'b010 in the same cycle; next cycle rf_we = 1, rf_wa = 5, rf_wd = 0xDEADBEEF; register 5 reads 0xDEADBEEF after the following negedge.
- Round-robin: all three requesters held valid for 6 cycles → grants 0, 1, 2, 0, 1, 2; one rf_we pulse per cycle.
- Zero register: requester 0 writes wa = 0, wd = 0x1234 → req_ready[0] = 1, rf_we stays 0; rsv_en with rsv_wa = 0 leaves chk_busy for register 0 at 0.
- Scoreboard counting (CNT_W = 2):
  - reserve register 8 twice → chk_busy1 = 1 with chk_ra1 = 8
  - one write to 8 accepted → chk_busy1 still 1
  - reserve 8 and accept a write to 8 in the same cycle → count stays 1
  - final accepted write to 8 → chk_busy1 = 0
- Saturation (CNT_W = 2): reserve register 9 three times → rsv_full = 1 with rsv_wa = 9; a fourth rsv_en is ignored; three accepted writes to 9 → chk_busy = 0.
